// File: rtl/restoring_divider_8_4.sv
// Sequential 8/4 unsigned restoring divider, one quotient bit per clock, start/stop handshake.
// Optional macro DIV_ZERO_TRAP_EN: a zero divisor finishes one cycle after acceptance and raises dz.
//
// state | meaning
// IDLE  | waiting for the first start after reset
// RUN   | iterating, one quotient bit per edge
// DONE  | Q/R/stop hold the finished result, ready for a new start
module restoring_divider_8_4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] X,
  input  logic [3:0] Y,
  output logic [7:0] Q,
  output logic [3:0] R,
  output logic       busy,
  output logic       stop,
  output logic       dz
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  logic [4:0] a;
  logic [7:0] d;
  logic [3:0] b;
  logic [2:0] cnt;

  logic [5:0] a_sh;
  logic       no_borrow;
  logic [4:0] a_nxt;
  logic [7:0] d_nxt;
  logic       trap_hit;

  // Compare on the full shifted value so a zero divisor still yields Q=FF, R=X[3:0].
  always_comb begin
    a_sh      = {a, d[7]};
    no_borrow = (a_sh >= {2'b00, b});
    a_nxt     = a_sh[4:0];
    d_nxt     = {d[6:0], 1'b0};
    if (no_borrow) begin
      a_nxt = a_sh[4:0] - {1'b0, b};
      d_nxt = {d[6:0], 1'b1};
    end
  end

`ifdef DIV_ZERO_TRAP_EN
  logic dz_q;
  assign trap_hit = (b == 4'd0);
  assign dz       = dz_q;
`else
  assign trap_hit = 1'b0;
  assign dz       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a     <= '0;
      d     <= '0;
      b     <= '0;
      cnt   <= '0;
      Q     <= '0;
      R     <= '0;
      busy  <= 1'b0;
      stop  <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      dz_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            b     <= Y;
            d     <= X;
            a     <= '0;
            cnt   <= '0;
            stop  <= 1'b0;
            busy  <= 1'b1;
`ifdef DIV_ZERO_TRAP_EN
            dz_q  <= 1'b0;
`endif
            state <= RUN;
          end
        end
        RUN: begin
          if (trap_hit) begin
            Q     <= 8'hFF;
            R     <= d[3:0];
            stop  <= 1'b1;
            busy  <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
            dz_q  <= 1'b1;
`endif
            state <= DONE;
          end else begin
            a   <= a_nxt;
            d   <= d_nxt;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              Q     <= d_nxt;
              R     <= a_nxt[3:0];
              stop  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
